// File: rtl/mosq_detector_bank.sv
`default_nettype none
// ============================================================================
// Module   : mosq_detector_bank
// Brief    : Multi-channel debounced mosquito presence detector with a shared
//            saturating detection event counter.
// Revision : 1.0
// ============================================================================
module mosq_detector_bank #(
  parameter int N_CH       = 4,
  parameter int ON_THRESH  = 4,
  parameter int OFF_THRESH = 500,
  parameter int EVT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic [N_CH-1:0]   is_large,
  input  logic              clr_cnt,
  output logic [N_CH-1:0]   is_mosq,
  output logic [N_CH-1:0]   det_pulse,
  output logic              any_mosq,
  output logic [EVT_W-1:0]  evt_cnt
);

  localparam int RUN_W  = $clog2(ON_THRESH + 1);
  localparam int HOLD_W = $clog2(OFF_THRESH + 1);
  localparam int CNT_W  = $clog2(N_CH + 1);
  localparam int SUM_W  = EVT_W + CNT_W + 1;

  localparam logic [RUN_W-1:0]  ON_MAX  = RUN_W'(ON_THRESH);
  localparam logic [HOLD_W-1:0] OFF_MAX = HOLD_W'(OFF_THRESH);
  localparam logic [EVT_W-1:0]  EVT_MAX = '1;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_DETECTED = 1'b1
  } state_e;

  logic [N_CH-1:0] w_pulse_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d, run_inc;
    logic [HOLD_W-1:0]  hold_q, hold_d, hold_inc;
    logic               pulse_q, pulse_d;

    assign run_inc  = (run_q == ON_MAX)   ? run_q  : run_q + 1'b1;
    assign hold_inc = (hold_q == OFF_MAX) ? hold_q : hold_q + 1'b1;

    always_comb begin
      state_d = state_q;
      run_d   = run_q;
      hold_d  = hold_q;
      pulse_d = 1'b0;
      if (in_en) begin
        case (state_q)
          S_IDLE: begin
            if (!is_large[i]) begin
              run_d = '0;
            end else if (run_inc == ON_MAX) begin
              state_d = S_DETECTED;
              pulse_d = 1'b1;
              run_d   = '0;
              hold_d  = '0;
            end else begin
              run_d = run_inc;
            end
          end
          default: begin
            // A large sample retriggers the release hold.
            if (is_large[i]) begin
              hold_d = '0;
            end else if (hold_inc == OFF_MAX) begin
              state_d = S_IDLE;
              run_d   = '0;
              hold_d  = '0;
            end else begin
              hold_d = hold_inc;
            end
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        run_q   <= '0;
        hold_q  <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        run_q   <= run_d;
        hold_q  <= hold_d;
        pulse_q <= pulse_d;
      end
    end

    assign w_pulse_d[i] = pulse_d;
    assign is_mosq[i]   = (state_q == S_DETECTED);
    assign det_pulse[i] = pulse_q;
  end : g_ch

  assign any_mosq = |is_mosq;

  logic [EVT_W-1:0] evt_q, evt_d, evt_base;
  logic [CNT_W-1:0] pop;
  logic [SUM_W-1:0] evt_sum;

  // Clear drops the old total but keeps detections landing on the same edge.
  always_comb begin
    pop = '0;
    for (int k = 0; k < N_CH; k++) begin
      pop = pop + CNT_W'(w_pulse_d[k]);
    end
    evt_base = clr_cnt ? '0 : evt_q;
    evt_sum  = SUM_W'(evt_base) + SUM_W'(pop);
    evt_d    = (evt_sum > SUM_W'(EVT_MAX)) ? EVT_MAX : evt_sum[EVT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign evt_cnt = evt_q;

endmodule
`default_nettype wire

// File: tb/tb_mosq_detector_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_mosq_detector_bank
// Brief    : Directed scenarios plus randomized traffic against a sample-level
//            reference model of the detector bank.
// Revision : 1.0
// ============================================================================
module tb_mosq_detector_bank;

  localparam int N_CH       = 4;
  localparam int ON_THRESH  = 4;
  localparam int OFF_THRESH = 8;
  localparam int EVT_W      = 4;
  localparam int EVT_LIMIT  = (1 << EVT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_en;
  logic [N_CH-1:0]  is_large;
  logic             clr_cnt;
  logic [N_CH-1:0]  is_mosq;
  logic [N_CH-1:0]  det_pulse;
  logic             any_mosq;
  logic [EVT_W-1:0] evt_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: consecutive-sample tallies and a plain integer total.
  int              m_large_run [N_CH];
  int              m_small_run [N_CH];
  bit              m_present   [N_CH];
  logic [N_CH-1:0] m_pulse;
  int              m_total;

  always #5 clk = ~clk;

  mosq_detector_bank #(
    .N_CH       (N_CH),
    .ON_THRESH  (ON_THRESH),
    .OFF_THRESH (OFF_THRESH),
    .EVT_W      (EVT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_en     (in_en),
    .is_large  (is_large),
    .clr_cnt   (clr_cnt),
    .is_mosq   (is_mosq),
    .det_pulse (det_pulse),
    .any_mosq  (any_mosq),
    .evt_cnt   (evt_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_large_run[c] = 0;
      m_small_run[c] = 0;
      m_present[c]   = 1'b0;
    end
    m_pulse = '0;
    m_total = 0;
  endtask

  task automatic model_step(input logic en, input logic [N_CH-1:0] lg, input logic clr);
    int detections;
    detections = 0;
    m_pulse    = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (en) begin
        if (!m_present[c]) begin
          m_large_run[c] = lg[c] ? m_large_run[c] + 1 : 0;
          if (m_large_run[c] >= ON_THRESH) begin
            m_present[c]   = 1'b1;
            m_pulse[c]     = 1'b1;
            m_large_run[c] = 0;
            m_small_run[c] = 0;
            detections++;
          end
        end else begin
          m_small_run[c] = lg[c] ? 0 : m_small_run[c] + 1;
          if (m_small_run[c] >= OFF_THRESH) begin
            m_present[c]   = 1'b0;
            m_large_run[c] = 0;
            m_small_run[c] = 0;
          end
        end
      end
    end
    m_total = (clr ? 0 : m_total) + detections;
    if (m_total > EVT_LIMIT) m_total = EVT_LIMIT;
  endtask

  task automatic check_all(input string tag);
    logic [N_CH-1:0] exp_mosq;
    for (int c = 0; c < N_CH; c++) exp_mosq[c] = m_present[c];
    check_eq({tag, "_is_mosq"},   32'(is_mosq),   32'(exp_mosq));
    check_eq({tag, "_det_pulse"}, 32'(det_pulse), 32'(m_pulse));
    check_eq({tag, "_any_mosq"},  32'(any_mosq),  32'(|exp_mosq));
    check_eq({tag, "_evt_cnt"},   32'(evt_cnt),   32'(m_total));
  endtask

  task automatic step(input string tag, input logic en, input logic [N_CH-1:0] lg, input logic clr);
    in_en    = en;
    is_large = lg;
    clr_cnt  = clr;
    @(posedge clk);
    model_step(en, lg, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [N_CH-1:0] lg;
    logic            en;
    logic            clr;
    int              p_large;
    int              cnt_before;

    rst      = 1'b1;
    in_en    = 1'b0;
    is_large = '0;
    clr_cnt  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic detect on ch0.
    for (int k = 0; k < ON_THRESH; k++) step("t1", 1'b1, 4'b0001, 1'b0);
    check_eq("t1_pulse0", 32'(det_pulse[0]), 32'd1);
    check_eq("t1_cnt",    32'(evt_cnt),      32'd1);
    check_eq("t1_any",    32'(any_mosq),     32'd1);
    step("t1b", 1'b0, 4'b0001, 1'b0);
    check_eq("t1_pulse_gone", 32'(det_pulse[0]), 32'd0);

    // Debounce break on ch1 (ch0 held present with large samples).
    step("t2", 1'b1, 4'b0011, 1'b0);
    step("t2", 1'b1, 4'b0011, 1'b0);
    step("t2", 1'b1, 4'b0011, 1'b0);
    step("t2", 1'b1, 4'b0001, 1'b0);
    step("t2", 1'b1, 4'b0011, 1'b0);
    step("t2", 1'b1, 4'b0011, 1'b0);
    step("t2", 1'b1, 4'b0011, 1'b0);
    check_eq("t2_no_detect", 32'(is_mosq[1]), 32'd0);
    step("t2", 1'b1, 4'b0001, 1'b0);
    // Stalled cycles inside a run are skipped, not counted as breaks.
    step("t2", 1'b1, 4'b0011, 1'b0);
    step("t2", 1'b1, 4'b0011, 1'b0);
    repeat (5) step("t2s", 1'b0, 4'b0000, 1'b0);
    step("t2", 1'b1, 4'b0011, 1'b0);
    check_eq("t2_third_no_detect", 32'(is_mosq[1]), 32'd0);
    step("t2", 1'b1, 4'b0011, 1'b0);
    check_eq("t2_detect_pulse", 32'(det_pulse[1]), 32'd1);
    check_eq("t2_cnt",          32'(evt_cnt),      32'd2);

    // Retriggerable hold on ch0 (ch1 kept present).
    repeat (7) step("t3", 1'b1, 4'b0010, 1'b0);
    step("t3", 1'b1, 4'b0011, 1'b0);
    repeat (7) step("t3", 1'b1, 4'b0010, 1'b0);
    check_eq("t3_still_present", 32'(is_mosq[0]), 32'd1);
    step("t3", 1'b1, 4'b0010, 1'b0);
    check_eq("t3_released", 32'(is_mosq[0]), 32'd0);

    // Simultaneous detection on ch0, ch2, ch3.
    cnt_before = int'(evt_cnt);
    repeat (ON_THRESH) step("t4", 1'b1, 4'b1111, 1'b0);
    check_eq("t4_pulse", 32'(det_pulse), 32'b1101);
    check_eq("t4_cnt",   32'(evt_cnt),   32'(cnt_before + 3));

    // Saturation, then clear coinciding with a two-channel detection.
    for (int r = 0; r < 3; r++) begin
      repeat (OFF_THRESH) step("t5r", 1'b1, 4'b0000, 1'b0);
      repeat (ON_THRESH)  step("t5d", 1'b1, 4'b1111, 1'b0);
    end
    check_eq("t5_saturated", 32'(evt_cnt), 32'd15);
    repeat (OFF_THRESH) step("t5r", 1'b1, 4'b0000, 1'b0);
    repeat (ON_THRESH - 1) step("t5c", 1'b1, 4'b0011, 1'b0);
    step("t5c", 1'b1, 4'b0011, 1'b1);
    check_eq("t5_clear_keeps_hits", 32'(evt_cnt), 32'd2);

    // Async reset while ch0 is mid-hold.
    repeat (5) step("t6h", 1'b1, 4'b0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("t6_mosq_rst", 32'(is_mosq), 32'd0);
    check_eq("t6_cnt_rst",  32'(evt_cnt), 32'd0);
    check_eq("t6_any_rst",  32'(any_mosq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (ON_THRESH - 1) step("t6", 1'b1, 4'b0001, 1'b0);
    check_eq("t6_three_no_detect", 32'(is_mosq[0]), 32'd0);
    step("t6", 1'b1, 4'b0001, 1'b0);
    check_eq("t6_fourth_detects", 32'(is_mosq[0]), 32'd1);

    // Randomized traffic alternating between busy and quiet phases.
    p_large = 85;
    for (int k = 0; k < 600; k++) begin
      if (k % 50 == 0) p_large = ((k / 50) % 2 == 1) ? 15 : 85;
      en  = ($urandom_range(99) < 80);
      for (int c = 0; c < N_CH; c++) lg[c] = ($urandom_range(99) < p_large);
      clr = ($urandom_range(99) < 4);
      step("rnd", en, lg, clr);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
